counter_param: RTL
==================

Name: counter_param

Overview:
- Parametrised successor to the team's fixed 4-bit free-running counter.
- Adds generic width, runtime terminal value, up/down direction, enable, synchronous load, and a wrap or saturate mode.
- Provides a terminal-count pulse, a toggle output at half the wrap rate, and a sticky overflow flag.
- Used as the general timebase and event counter for LED blinkers, PWM frames and divider chains.

Parameters:
- WIDTH, 4: counter width in bits. Legal range is 2..32.
- SATURATE, 0: 0 means wrap at the limit; 1 means hold at the limit and flag overflow.
- PRESCALE, 1: step divider, used only when CNT_PRESCALE_EN is defined. Legal range is 1..65535.

Ports:
- sys_clk, in, 1: sole clock. Everything is on the rising edge.
- sys_rst, in, 1: reset. Synchronous, active-high.
- en, in, 1: count enable. One step per cycle while high.
- dir, in, 1: 1 counts up, 0 counts down.
- load, in, 1: synchronous load strobe.
- load_val, in, WIDTH: value written to cnt on load.
- cnt_max, in, WIDTH: runtime terminal value. Sampled every cycle.
- clr_ovf, in, 1: clears ovf.
- cnt, out, WIDTH: current count.
- tc, out, 1: registered terminal-count pulse.
- out, out, 1: registered toggle. Flips on every wrap.
- ovf, out, 1: sticky saturation flag. Meaningful only when SATURATE=1.

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst, synchronous, active-high.
- Reset: on a sys_clk edge with sys_rst=1, cnt=0, tc=0, out=0, ovf=0, prescaler=0. Reset overrides every other input.
- Priority per edge: sys_rst, then load, then en step, then hold.
- Load:
  - cnt <= load_val, regardless of en or cnt_max.
  - tc=0 that cycle; out and ovf unchanged; prescaler cleared.
  - load_val > cnt_max is legal.
- Up step (dir=1):
  - If cnt < cnt_max: cnt+1.
  - If cnt >= cnt_max, this is the limit step:
    - Wrap mode: cnt <= 0.
    - Saturate mode: cnt <= cnt_max.
  - Using >= means a lowered cnt_max, or a load above it, terminates on the next step.
- Down step (dir=0):
  - If cnt > 0: cnt-1.
  - If cnt == 0, this is the limit step:
    - Wrap mode: cnt <= cnt_max.
    - Saturate mode: cnt stays 0.
- tc:
  - Set to 1 on exactly the edge performing a limit step; 0 on all other edges.
  - tc is therefore high during the first cycle of the wrapped or held value.
  - With en held in saturate mode, tc stays high every cycle.
- out: toggles on every wrap-mode limit step. Never toggles in saturate mode.
- ovf:
  - Set on a saturate-mode limit step; cleared by clr_ovf.
  - If set and clear coincide, set wins.
- cnt_max == 0: up and down both give a limit step every enabled cycle.
  - Wrap mode: cnt=0, tc high continuously, out toggles every cycle.
- dir may change on any cycle; the new direction applies on that cycle's step.
- Latency: every output is registered, with one edge from input to effect.
- Arithmetic is pure WIDTH-bit with no carry-out, so the counter covers the full range 0..2^WIDTH-1.
- en=0: all state holds and tc=0.

Optional Feature:
- Macro: CNT_PRESCALE_EN.
- Defined:
  - Adds an internal prescaler of ceil(log2(PRESCALE)) bits that counts cycles with en=1.
  - The main counter steps only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - tc, out and ovf follow the stepped events only.
  - The prescaler is cleared by sys_rst and load, and holds when en=0.
  - PRESCALE=1 behaves identically to the macro being undefined.
- Undefined: no prescaler logic; one step per enabled cycle; PRESCALE is ignored.

Test Plan:
- Wrap up-count: WIDTH=4, SATURATE=0, cnt_max=15, dir=1, en=1 after reset.
  - cnt runs 0..15 then 0.
  - tc high for 1 cycle every 16, coinciding with cnt=0.
  - out period is 32 cycles.
- Wrap down-count: cnt_max=9, dir=0, from reset.
  - Sequence is 0, 9, 8, …, 1, 0, 9.
  - tc high on each cycle where cnt=9 after a reload.
  - out toggles on each reload.
- Saturation: SATURATE=1, cnt_max=5, dir=1.
  - cnt holds 5; ovf=1 from the 6th step; tc high continuously while en=1.
  - clr_ovf=1 with en=0 gives ovf=0.
  - clr_ovf=1 with en=1 at the limit leaves ovf at 1.
- Load and limit change: during the count at cnt=3, apply load=1 with load_val=12 and cnt_max=10.
  - Next cycle: cnt=12, tc=0.
  - Following up step: cnt=0, tc=1, out toggles.
- Mid-operation reset: assert sys_rst at cnt=7 with ovf=1 and out=1, simultaneously with load=1.
  - Next cycle: cnt=0, tc=0, out=0, ovf=0; the load is ignored.
- Prescaler: define CNT_PRESCALE_EN, PRESCALE=3, en=1.
  - cnt advances every 3rd cycle.
  - Drop en for 2 cycles mid-period: step timing is delayed by exactly 2 cycles.
  - load resets the 3-cycle phase.

Source files
------------

// File: rtl/counter_param.sv
// Parametrised up/down timebase counter with wrap or saturate mode, terminal-count pulse and toggle output.
// Optional step prescaler is compiled in when CNT_PRESCALE_EN is defined.
module counter_param #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cnt_max,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             out,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_param
    $error("counter_param: WIDTH or PRESCALE out of legal range");
  end

  localparam logic SAT_MODE = (SATURATE != 0);

  logic step;
  logic limit;

  // Limit test uses >= so a lowered cnt_max or an out-of-range load terminates on the next up step.
  function automatic logic at_limit(input logic [WIDTH-1:0] c,
                                    input logic [WIDTH-1:0] m,
                                    input logic             up);
    return up ? (c >= m) : (c == '0);
  endfunction

  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] c,
                                                  input logic [WIDTH-1:0] m,
                                                  input logic             up,
                                                  input logic             lim);
    logic [WIDTH-1:0] n;
    if (lim) begin
      if (up) n = SAT_MODE ? m : '0;
      else    n = SAT_MODE ? '0 : m;
    end else begin
      n = up ? c + WIDTH'(1) : c - WIDTH'(1);
    end
    return n;
  endfunction

`ifdef CNT_PRESCALE_EN
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || load)
      ps_cnt <= '0;
    else if (en)
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
  end

  assign step = en && (ps_cnt == PS_LAST);
`else
  assign step = en;
`endif

  assign limit = at_limit(cnt, cnt_max, dir);

  // Count register stage: reset > load > step > hold
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= '0;
      tc  <= 1'b0;
      out <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      tc  <= 1'b0;
    end else if (step) begin
      cnt <= next_count(cnt, cnt_max, dir, limit);
      tc  <= limit;
      if (limit && !SAT_MODE)
        out <= ~out;
      if (limit && SAT_MODE)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule
